irom_ctrl: RTL and testbench

Parametrised instruction-memory controller that replaces the fixed single-mode instruction ROM. It accepts a boot-time program-load stream over a valid/ready port with byte enables and holds the core in a boot-wait state until the last word is written. After boot it serves instruction fetches with configurable latency and a qualified read-valid, and it continues to allow runtime patch writes. It sits between the debug/UART loader and the core's fetch stage.

---
 rtl/irom_ctrl.sv | 129 ++++++++++++
 tb/tb_irom_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irom_ctrl.sv
// Instruction-memory controller: boot-time program load over valid/ready with byte enables,
// then fetch service with configurable latency and runtime patch writes.
module irom_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    prog_valid_i,
    output logic                    prog_ready_o,
    input  logic [ADDR_WIDTH-1:0]   prog_addr_i,
    input  logic [DATA_WIDTH-1:0]   prog_data_i,
    input  logic [DATA_WIDTH/8-1:0] prog_be_i,
    input  logic                    prog_last_i,
    input  logic                    rd_req_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_valid_o,
    output logic                    boot_done_o,
    output logic                    err_o,
    output logic [DEPTH_LOG2:0]     load_cnt_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int NB    = DATA_WIDTH / 8;
    localparam logic [DEPTH_LOG2:0] CNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic {
        BOOT_WAIT = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_fire, wr_bad, wr_ok, rd_fire;
    logic [DEPTH_LOG2-1:0] wr_idx, rd_idx, rd_idx_q;
    logic                  rd_req_q;
    logic                  v1;
    logic [DATA_WIDTH-1:0] d1;
    logic                  rd_addr_unused;

    assign prog_ready_o   = ~rst;
    assign wr_fire        = prog_valid_i & prog_ready_o;
    assign wr_bad         = (prog_addr_i[1:0] != 2'b00) ||
                            (prog_addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2] != '0);
    assign wr_ok          = wr_fire & ~wr_bad;
    assign wr_idx         = prog_addr_i[DEPTH_LOG2+1:2];
    assign rd_idx         = rd_addr_i[DEPTH_LOG2+1:2];
    assign rd_fire        = rd_req_i & (state == RUN) & ~rst;
    assign rd_addr_unused = ^{rd_addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2], rd_addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= BOOT_WAIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        boot_done_o = 1'b0;
        case (state)
            BOOT_WAIT: if (wr_fire && prog_last_i) state_nxt = RUN;
            RUN:       boot_done_o = 1'b1;
            default:   state_nxt = BOOT_WAIT;
        endcase
    end

    // Array is never cleared so an image survives a reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (prog_be_i[k]) mem[wr_idx][8*k +: 8] <= prog_data_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_o      <= 1'b0;
            load_cnt_o <= '0;
        end else if (wr_fire) begin
            if (wr_bad)                  err_o      <= 1'b1;
            else if (load_cnt_o != CNT_MAX) load_cnt_o <= load_cnt_o + CNT_ONE;
        end
    end

    // Array is read one edge after the request, so a same-cycle write is already merged in.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_req_q <= 1'b0;
            v1       <= 1'b0;
            d1       <= '0;
        end else begin
            rd_req_q <= rd_fire;
            v1       <= rd_req_q;
            if (rd_req_q) d1 <= mem[rd_idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_fire) rd_idx_q <= rd_idx;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  v2;
            logic [DATA_WIDTH-1:0] d2;
            always_ff @(posedge clk) begin
                if (rst) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) d2 <= d1;
                end
            end
            assign rd_valid_o = v2;
            assign rd_data_o  = d2;
        end else begin : g_no_out_reg
            assign rd_valid_o = v1;
            assign rd_data_o  = d1;
        end
    endgenerate

endmodule

// File: tb/tb_irom_ctrl.sv
// Bench for irom_ctrl: two instances (OUT_REG 0 and 1) share stimulus and are checked every cycle
// against a word-array reference model.
module tb_irom_ctrl;

    localparam int MAXC = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_valid;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic [3:0]  prog_be;
    logic        prog_last;
    logic        rd_req;
    logic [31:0] rd_addr;

    logic        ready0, ready1, rvalid0, rvalid1, done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [10:0] cnt0, cnt1;

    logic [31:0] ref_mem [1024];
    bit          ref_run, ref_err;
    int          ref_cnt;
    bit          exp0_v [MAXC];
    bit          exp1_v [MAXC];
    logic [31:0] exp0_d [MAXC];
    logic [31:0] exp1_d [MAXC];
    logic [31:0] last0, last1;
    int          cyc;
    int          chk_cnt;
    int          pass_cnt;

    always #5 clk = ~clk;

    irom_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .prog_valid_i(prog_valid), .prog_ready_o(ready0),
        .prog_addr_i(prog_addr), .prog_data_i(prog_data), .prog_be_i(prog_be),
        .prog_last_i(prog_last), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_data_o(rdata0), .rd_valid_o(rvalid0), .boot_done_o(done0),
        .err_o(err0), .load_cnt_o(cnt0)
    );

    irom_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .prog_valid_i(prog_valid), .prog_ready_o(ready1),
        .prog_addr_i(prog_addr), .prog_data_i(prog_data), .prog_be_i(prog_be),
        .prog_last_i(prog_last), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_data_o(rdata1), .rd_valid_o(rvalid1), .boot_done_o(done1),
        .err_o(err1), .load_cnt_o(cnt1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    // Reference behaviour at one clock edge: writes land first, then a RUN-state read captures
    // the word and is due one edge later (OUT_REG=0) or two edges later (OUT_REG=1).
    task automatic model_edge();
        bit       bad;
        int       widx, ridx;
        bit       run_next;
        if (rst) begin
            ref_run = 0;
            ref_err = 0;
            ref_cnt = 0;
            for (int i = 0; i < 3; i++) begin
                exp0_v[cyc+i] = 0;
                exp1_v[cyc+i] = 0;
            end
            last0 = 32'h0;
            last1 = 32'h0;
        end else begin
            run_next = ref_run;
            if (prog_valid) begin
                bad  = (prog_addr % 4 != 0) || (prog_addr >= 32'd4096);
                widx = int'(prog_addr / 4) % 1024;
                if (bad) ref_err = 1;
                else begin
                    for (int k = 0; k < 4; k++)
                        if (prog_be[k]) ref_mem[widx][8*k +: 8] = prog_data[8*k +: 8];
                    if (ref_cnt < 1024) ref_cnt++;
                end
                if (prog_last) run_next = 1;
            end
            if (rd_req && ref_run) begin
                ridx = int'(rd_addr / 4) % 1024;
                exp0_v[cyc+1] = 1;
                exp0_d[cyc+1] = ref_mem[ridx];
                exp1_v[cyc+2] = 1;
                exp1_d[cyc+2] = ref_mem[ridx];
            end
            ref_run = run_next;
        end
    endtask

    task automatic checkOutput();
        if (exp0_v[cyc]) last0 = exp0_d[cyc];
        if (exp1_v[cyc]) last1 = exp1_d[cyc];
        check_val("ready0",  {31'h0, ready0},  {31'h0, ~rst});
        check_val("ready1",  {31'h0, ready1},  {31'h0, ~rst});
        check_val("rvalid0", {31'h0, rvalid0}, {31'h0, exp0_v[cyc]});
        check_val("rvalid1", {31'h0, rvalid1}, {31'h0, exp1_v[cyc]});
        check_val("rdata0",  rdata0, last0);
        check_val("rdata1",  rdata1, last1);
        check_val("done0",   {31'h0, done0},   {31'h0, ref_run});
        check_val("done1",   {31'h0, done1},   {31'h0, ref_run});
        check_val("err0",    {31'h0, err0},    {31'h0, ref_err});
        check_val("err1",    {31'h0, err1},    {31'h0, ref_err});
        check_val("cnt0",    {21'h0, cnt0},    32'(ref_cnt));
        check_val("cnt1",    {21'h0, cnt1},    32'(ref_cnt));
    endtask

    task automatic applyStimulus(input logic pv, input logic [31:0] pa, input logic [31:0] pd,
                                 input logic [3:0] be, input logic pl,
                                 input logic rq, input logic [31:0] ra);
        prog_valid = pv;
        prog_addr  = pa;
        prog_data  = pd;
        prog_be    = be;
        prog_last  = pl;
        rd_req     = rq;
        rd_addr    = ra;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Read with an optional same-cycle write, checking both latencies against a fixed word.
    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                              input logic pv, input logic [31:0] pd, input logic [3:0] be);
        applyStimulus(pv, addr, pd, be, 1'b0, 1'b1, addr);
        idle();
        check_val({tag, "_v0"}, {31'h0, rvalid0}, 32'h1);
        check_val({tag, "_d0"}, rdata0, exp);
        idle();
        check_val({tag, "_v1"}, {31'h0, rvalid1}, 32'h1);
        check_val({tag, "_d1"}, rdata1, exp);
    endtask

    initial begin
        logic [31:0] a, d, w40;
        int          idx;
        cyc = 0; chk_cnt = 0; pass_cnt = 0;
        ref_run = 0; ref_err = 0; ref_cnt = 0;
        last0 = 32'h0; last1 = 32'h0;
        for (int i = 0; i < MAXC; i++) begin
            exp0_v[i] = 0;
            exp1_v[i] = 0;
        end
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        idle();

        $display("[TB] boot load with fetches held off");
        applyStimulus(1'b1, 32'h0, 32'h00000013, 4'hF, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 32'h4, 32'h00100093, 4'hF, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 32'h8, 32'h00200113, 4'hF, 1'b0, 1'b1, 32'h0);
        check_val("boot_rdata", rdata0, 32'h0);
        applyStimulus(1'b1, 32'hC, 32'h00000073, 4'hF, 1'b1, 1'b1, 32'h0);
        check_val("boot_done", {31'h0, done0}, 32'h1);
        check_val("boot_cnt",  {21'h0, cnt0},  32'd4);
        idle();
        idle();
        read_check("rd0", 32'h0, 32'h00000013, 1'b0, 32'h0, 4'h0);
        read_check("rd4", 32'h4, 32'h00100093, 1'b0, 32'h0, 4'h0);
        read_check("rd8", 32'h8, 32'h00200113, 1'b0, 32'h0, 4'h0);
        read_check("rdC", 32'hC, 32'h00000073, 1'b0, 32'h0, 4'h0);

        $display("[TB] bad writes");
        applyStimulus(1'b1, 32'h2,    32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0);
        idle();
        check_val("bad_err", {31'h0, err0}, 32'h1);
        check_val("bad_cnt", {21'h0, cnt1}, 32'd4);
        read_check("bad_rd0", 32'h0, 32'h00000013, 1'b0, 32'h0, 4'h0);

        for (int i = 4; i < 64; i++)
            applyStimulus(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, 1'b0, 32'h0);

        $display("[TB] byte-enable patch and collision");
        applyStimulus(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 32'h0);
        read_check("be_patch", 32'h8, 32'h00BB01DD, 1'b0, 32'h0, 4'h0);
        read_check("collide", 32'h4, 32'h12345678, 1'b1, 32'h12345678, 4'hF);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            idx = int'($urandom_range(0, 63));
            case ($urandom_range(0, 7))
                0:       a = 32'(idx * 4) | 32'($urandom_range(1, 3));
                1:       a = 32'h1000 | ($urandom & 32'hFFFF_FFFC);
                default: a = 32'(idx * 4);
            endcase
            d = $urandom;
            applyStimulus(1'($urandom), a, d, 4'($urandom), 1'($urandom), 1'($urandom),
                          ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63) * 4)
                          | 32'($urandom_range(0, 3)));
        end
        idle();
        idle();

        $display("[TB] counter saturation with empty byte enables");
        for (int n = 0; n < 1000; n++)
            applyStimulus(1'b1, 32'h0, $urandom, 4'h0, 1'b0, 1'b0, 32'h0);
        idle();
        check_val("sat_cnt", {21'h0, cnt0}, 32'd1024);
        read_check("sat_rd0", 32'h0, ref_mem[0], 1'b0, 32'h0, 4'h0);

        $display("[TB] reset mid-read and mid-load");
        w40 = ref_mem[40];
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hA0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        idle();
        check_val("rst_v0",   {31'h0, rvalid0}, 32'h0);
        check_val("rst_done", {31'h0, done0},   32'h0);
        check_val("rst_cnt",  {21'h0, cnt0},    32'h0);
        idle();
        check_val("rst_v1",   {31'h0, rvalid1}, 32'h0);
        applyStimulus(1'b1, 32'h0, 32'h00000013, 4'hF, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h4, 32'h00100093, 4'hF, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        applyStimulus(1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'h8);
        rst = 1'b0;
        idle();
        check_val("rst2_cnt",  {21'h0, cnt1}, 32'h0);
        check_val("rst2_done", {31'h0, done1}, 32'h0);
        applyStimulus(1'b1, 32'h0, 32'h00000013, 4'hF, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h4, 32'h00100093, 4'hF, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h8, 32'h00200113, 4'hF, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'hC, 32'h00000073, 4'hF, 1'b1, 1'b0, 32'h0);
        check_val("reload_cnt", {21'h0, cnt0}, 32'd4);
        read_check("keep_w40", 32'hA0, w40, 1'b0, 32'h0, 4'h0);
        read_check("reload_8", 32'h8, 32'h00200113, 1'b0, 32'h0, 4'h0);
        idle();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
